// File: rtl/shift_reg_pkg.sv
// Shared state and shift-control encodings for the serial receiver family.
// Optional even-parity stage is selected elsewhere by SIPO_PARITY_EN.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NOP     = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2,
        LOAD    = 2'd3
    } shift_op_t;

    // Counter width covering 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Saturating bit counter 0..N-1 with synchronous clear and terminal-count flag.
module tick_counter
    import shift_reg_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = cnt_width(N)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc = (r_count == CW'(N - 1));
    assign o_tc = w_tc;

    // Holds at N-1 rather than wrapping; the FSM clears it on return to idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_rx_start_done.sv
// Start-triggered MSB-first serial-to-parallel receiver with done pulse.
// Define SIPO_PARITY_EN to add an even-parity bit after the data word.
module serial_rx_start_done
    import shift_reg_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Trigger,
    input  logic         start,
    input  logic         sin,
    output logic [N-1:0] data,
    output logic         busy,
    output logic         last_tick,
    output logic         done_tick,
    output logic         parity_err
);

    state_t       r_state;
    state_t       w_next;
    shift_op_t    w_op;
    logic [N-1:0] r_sreg;
    logic [N-1:0] r_data;
    logic [N-1:0] w_shifted;
    logic         w_tc;
    logic         w_cnt_en;
    logic         w_cnt_clr;
    logic         w_load_data;
`ifdef SIPO_PARITY_EN
    logic         r_perr;
    logic         w_load_par;
`endif

    assign w_shifted = {r_sreg[N-2:0], sin};
    assign w_cnt_clr = (r_state == IDLE);

    tick_counter #(
        .N (N)
    ) u_tick_counter (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (w_cnt_en),
        .i_clr (w_cnt_clr),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_op        = NOP;
        w_cnt_en    = 1'b0;
        w_load_data = 1'b0;
`ifdef SIPO_PARITY_EN
        w_load_par  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SHIFT;
                    w_op   = LOAD;
                end
            end
            SHIFT: begin
                if (Trigger) begin
                    w_op     = SHIFT_L;
                    w_cnt_en = 1'b1;
                    if (w_tc) begin
`ifdef SIPO_PARITY_EN
                        w_next = PARITY;
`else
                        w_next      = DONE;
                        w_load_data = 1'b1;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef SIPO_PARITY_EN
                if (Trigger) begin
                    w_next     = DONE;
                    w_load_par = 1'b1;
                end
`else
                w_next = IDLE;
`endif
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg <= '0;
        end else begin
            case (w_op)
                LOAD:    r_sreg <= '0;
                SHIFT_L: r_sreg <= w_shifted;
                SHIFT_R: r_sreg <= {sin, r_sreg[N-1:1]};
                default: r_sreg <= r_sreg;
            endcase
        end
    end

    // Without parity the word is captured on the final data edge itself, so
    // it comes from the shifted value rather than the register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_load_data) begin
            r_data <= w_shifted;
`ifdef SIPO_PARITY_EN
        end else if (w_load_par) begin
            r_data <= r_sreg;
`endif
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perr <= 1'b0;
        end else if (w_load_par) begin
            r_perr <= (^r_sreg) ^ sin;
        end
    end
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = r_data;
    assign busy      = (r_state == SHIFT) || (r_state == PARITY);
    assign last_tick = (r_state == SHIFT) && w_tc;
    assign done_tick = (r_state == DONE);

endmodule

// File: doc/serial_rx_start_done.md
SERIAL_RX_START_DONE -- requirements
Module: serial_rx_start_done

Interface
REQ-001 SHALL have parameter: N, 8, word width in bits; legal range N >= 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Trigger  input  1  bit strobe; a serial bit is sampled only on clk edges where Trigger=1.
REQ-005 SHALL have port: start  input  1  begin reception of one word.
REQ-006 SHALL have port: sin  input  1  serial data in, MSB first.
REQ-007 SHALL have port: data  output  N  last completed word, registered.
REQ-008 SHALL have port: busy  output  1  high while in SHIFT or PARITY.
REQ-009 SHALL have port: last_tick  output  1  high while in SHIFT with bit count = N-1 (combinational from state/count).
REQ-010 SHALL have port: done_tick  output  1  one-clk pulse when data is updated.
REQ-011 SHALL have port: parity_err  output  1  parity result of last word; constant 0 when parity is compiled out.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, PARITY (only with SIPO_PARITY_EN), DONE.
REQ-013 In IDLE, start=1 on a clk edge SHALL move to SHIFT with bit count 0; Trigger is ignored in IDLE.
REQ-014 In SHIFT, each clk edge with Trigger=1 SHALL shift sin into the LSB of the shift register ({s_reg[N-2:0], sin}) and increment the count.
REQ-015 The edge sampling bit N-1 SHALL go to PARITY if enabled, else to DONE and load data from the complete shifted word.
REQ-016 DONE SHALL last exactly one clk with done_tick=1, then return to IDLE; done_tick SHALL be asserted in the cycle after the final sampling edge.
REQ-017 start while busy or in DONE SHALL be ignored; start and the final Trigger edge in the same cycle SHALL not start a new word.
REQ-018 Trigger=0 in SHIFT/PARITY SHALL hold all state; no timeout exists.
REQ-019 data and parity_err SHALL hold their values until the next done_tick.
REQ-020 Bit counter SHALL be wide enough for 0..N-1 and SHALL never wrap past N-1.

Reset
REQ-021 reset=1 SHALL immediately force state IDLE, shift register 0, count 0, data 0, done_tick 0, parity_err 0, busy 0, independent of clk and Trigger.
REQ-022 reset mid-word SHALL discard the partial word; no done_tick SHALL follow.

Configuration
REQ-023 Macro SIPO_PARITY_EN defined: after N data bits, PARITY state SHALL sample one extra bit on Trigger=1, and parity_err SHALL be (XOR of data bits XOR parity bit), i.e. 1 on even-parity violation, updated with data.
REQ-024 Macro SIPO_PARITY_EN undefined: no PARITY state, SHIFT goes directly to DONE, parity_err tied 0.

Structure
REQ-025 State encodings (IDLE/SHIFT/PARITY/DONE) and the shared shift-control codes (NOP/SHIFT_L/SHIFT_R/LOAD) SHALL reside in shared package shift_reg_pkg.
REQ-026 Bit count SHALL be a sub-module tick_counter (enable, clear, terminal-count output); FSM and shift register stay in the top.

Verification
REQ-027 N=8, no parity: start pulse, then 8 Trigger strobes with sin=1,0,1,0,0,1,0,1 -> data=8'hA5, done_tick high exactly one clk after the 8th strobe, busy low afterward.
REQ-028 Trigger gaps: same word with 3 idle clks between strobes -> data=8'hA5; last_tick high only during the wait for the 8th strobe.
REQ-029 start re-asserted after 4th bit of 8'h3C -> ignored; data=8'h3C, one done_tick.
REQ-030 reset asserted after 5th bit, then full word 8'hF0 -> no done_tick for the partial word; data=8'hF0 after the second word.
REQ-031 SIPO_PARITY_EN: 8'hA5 + parity bit 0 -> parity_err=0; 8'hA5 + parity bit 1 -> parity_err=1; done_tick after the 9th strobe.
REQ-032 Trigger strobes in IDLE with no start -> state, data and done_tick unchanged (data stays 0 after reset).
